// File: rtl/pixel_downscaler_nxn.sv
// Streaming grayscale S x S block pooling (avg/max/min/decimate) with a single
// line of accumulators, one-slot output register, frame sync and error flag.
module pixel_downscaler_nxn #(
  parameter int GS_PXL_W   = 8,
  parameter int COL_NUM    = 640,
  parameter int ROW_NUM    = 480,
  parameter int SCALE_LOG2 = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          mode_i,
  input  logic [GS_PXL_W-1:0] dsm_pxl_i,
  input  logic                dsm_pxl_vld_i,
  input  logic                dsm_sof_i,
  output logic                dsm_pxl_rdy_o,
  output logic [GS_PXL_W-1:0] pat_pxl_o,
  output logic                pat_pxl_vld_o,
  output logic                pat_last_o,
  input  logic                pat_rdy_i,
  output logic                frm_err_o
);
  localparam int S     = 1 << SCALE_LOG2;
  localparam int ACC_W = GS_PXL_W + 2*SCALE_LOG2;
  localparam int NBLK  = COL_NUM / S;
  localparam int CW    = (COL_NUM > 1) ? $clog2(COL_NUM) : 1;
  localparam int RW    = (ROW_NUM > 1) ? $clog2(ROW_NUM) : 1;
  localparam int BW    = (NBLK > 1) ? $clog2(NBLK) : 1;
  localparam logic [CW-1:0]         COL_LAST = CW'(COL_NUM - 1);
  localparam logic [RW-1:0]         ROW_LAST = RW'(ROW_NUM - 1);
  localparam logic [SCALE_LOG2-1:0] SUB_LAST = '1;

  logic [CW-1:0]         col_q, col_e;
  logic [RW-1:0]         row_q, row_e;
  logic [1:0]            mode_q;
  logic [ACC_W-1:0]      h_acc, h_next, v_comb;
  logic [ACC_W-1:0]      lacc [NBLK];
  logic [BW-1:0]         blk;
  logic [SCALE_LOG2-1:0] sub_c, sub_r;
  logic [GS_PXL_W-1:0]   res;
  logic                  sof_v, first_px, completing, last_pos, in_hsk, out_hsk;

  // new = incoming contribution, old = value already accumulated
  function automatic logic [ACC_W-1:0] comb(input logic [1:0] m,
                                            input logic [ACC_W-1:0] nw,
                                            input logic [ACC_W-1:0] old);
    case (m)
      2'd0:    comb = nw + old;
      2'd1:    comb = (nw > old) ? nw : old;
      2'd2:    comb = (nw < old) ? nw : old;
      default: comb = old;
    endcase
  endfunction

  // An accepted sof restarts the frame at (0,0) regardless of counter state
  assign sof_v    = dsm_sof_i & dsm_pxl_vld_i;
  assign col_e    = sof_v ? '0 : col_q;
  assign row_e    = sof_v ? '0 : row_q;
  assign sub_c    = col_e[SCALE_LOG2-1:0];
  assign sub_r    = row_e[SCALE_LOG2-1:0];
  assign blk      = BW'(col_e >> SCALE_LOG2);
  assign first_px = (col_e == '0) && (row_e == '0);

  assign completing = (sub_c == SUB_LAST) && (sub_r == SUB_LAST);
  assign last_pos   = (col_e == COL_LAST) && (row_e == ROW_LAST);

  assign h_next = (sub_c == '0) ? ACC_W'(dsm_pxl_i) : comb(mode_q, ACC_W'(dsm_pxl_i), h_acc);
  assign v_comb = (sub_r == '0) ? h_next : comb(mode_q, h_next, lacc[blk]);
  assign res    = (mode_q == 2'd0) ? GS_PXL_W'(v_comb >> (2*SCALE_LOG2)) : v_comb[GS_PXL_W-1:0];

  assign dsm_pxl_rdy_o = ~(completing & pat_pxl_vld_o & ~pat_rdy_i);
  assign in_hsk        = dsm_pxl_vld_i & dsm_pxl_rdy_o;
  assign out_hsk       = pat_pxl_vld_o & pat_rdy_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q         <= '0;
      row_q         <= '0;
      mode_q        <= '0;
      h_acc         <= '0;
      frm_err_o     <= 1'b0;
      pat_pxl_vld_o <= 1'b0;
      pat_pxl_o     <= '0;
      pat_last_o    <= 1'b0;
    end else begin
      frm_err_o <= in_hsk & sof_v & ((col_q != '0) | (row_q != '0));
      if (in_hsk) begin
        h_acc <= h_next;
        if (first_px) mode_q <= mode_i;
        if (col_e == COL_LAST) begin
          col_q <= '0;
          row_q <= (row_e == ROW_LAST) ? '0 : row_e + 1'b1;
        end else begin
          col_q <= col_e + 1'b1;
          row_q <= row_e;
        end
      end
      // a new result overrides a same-cycle drain
      if (in_hsk && completing) begin
        pat_pxl_vld_o <= 1'b1;
        pat_pxl_o     <= res;
        pat_last_o    <= last_pos;
      end else if (out_hsk) begin
        pat_pxl_vld_o <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_hsk && (sub_c == SUB_LAST) && !completing) lacc[blk] <= v_comb;
  end
endmodule

// File: tb/tb_pixel_downscaler_nxn.sv
// Scoreboarded bench: two downscaler instances (S=2 on 4x2, S=4 on 4x4) driven
// with directed and random frames, checked against a block-pooling model.
module tb_pixel_downscaler_nxn;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]      vin, sof, prdy, ovld, olast, irdy, ferr;
  logic [1:0][1:0] mode;
  logic [1:0][7:0] pix, opx;

  pixel_downscaler_nxn #(.GS_PXL_W(8), .COL_NUM(4), .ROW_NUM(2), .SCALE_LOG2(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .mode_i(mode[0]), .dsm_pxl_i(pix[0]), .dsm_pxl_vld_i(vin[0]),
    .dsm_sof_i(sof[0]), .dsm_pxl_rdy_o(irdy[0]), .pat_pxl_o(opx[0]), .pat_pxl_vld_o(ovld[0]),
    .pat_last_o(olast[0]), .pat_rdy_i(prdy[0]), .frm_err_o(ferr[0]));

  pixel_downscaler_nxn #(.GS_PXL_W(8), .COL_NUM(4), .ROW_NUM(4), .SCALE_LOG2(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .mode_i(mode[1]), .dsm_pxl_i(pix[1]), .dsm_pxl_vld_i(vin[1]),
    .dsm_sof_i(sof[1]), .dsm_pxl_rdy_o(irdy[1]), .pat_pxl_o(opx[1]), .pat_pxl_vld_o(ovld[1]),
    .pat_last_o(olast[1]), .pat_rdy_i(prdy[1]), .frm_err_o(ferr[1]));

  typedef struct { int d; int l; } exp_t;
  exp_t q0[$], q1[$];
  int   vectors = 0, miscompares = 0;
  int   rmode[2];
  int   ferr_cnt[2];
  bit   gaps;
  logic [7:0] fr[16];

  task automatic chk(input string nm, input int act, input int expv);
    vectors++;
    if (act != expv) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  task automatic push_exp(input int i, input int d, input int l);
    exp_t e;
    e.d = d; e.l = l;
    if (i == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  // Reference: pool each S x S block of fr[], emitted in block-completion order
  task automatic model_push(input int i, input int cols, input int rows, input int lg, input int m);
    int s, sum, mx, mn, v, d;
    s = 1 << lg;
    for (int br = 0; br < rows/s; br++)
      for (int bc = 0; bc < cols/s; bc++) begin
        sum = 0; mx = 0; mn = 255;
        for (int r = 0; r < s; r++)
          for (int c = 0; c < s; c++) begin
            v = int'(fr[(br*s + r)*cols + bc*s + c]);
            sum += v;
            if (v > mx) mx = v;
            if (v < mn) mn = v;
          end
        case (m)
          0: d = sum / (s*s);
          1: d = mx;
          2: d = mn;
          default: d = int'(fr[br*s*cols + bc*s]);
        endcase
        push_exp(i, d, (br == rows/s - 1 && bc == cols/s - 1) ? 1 : 0);
      end
  endtask

  // Called at posedge+#1; returns at posedge+#1 after the accepting edge
  task automatic send_px(input int i, input logic [7:0] p, input logic s, input logic [1:0] m);
    int n;
    n = 0;
    pix[i] = p; sof[i] = s; mode[i] = m; vin[i] = 1'b1;
    @(negedge clk);
    while (!irdy[i] && n < 200) begin n++; @(negedge clk); end
    if (n >= 200) chk($sformatf("accept_timeout%0d", i), 0, 1);
    @(posedge clk); #1;
    vin[i] = 1'b0; sof[i] = 1'b0;
    if (gaps && $urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
  endtask

  task automatic send_frame(input int i, input int npx, input int m, input bit sofv);
    for (int k = 0; k < npx; k++)
      send_px(i, fr[k], (k == 0) && sofv, (k == 0) ? 2'(m) : 2'($urandom_range(0, 3)));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 5000) begin n++; @(negedge clk); end
    chk("drain_pending", q0.size() + q1.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic chk_reset(input int i);
    chk($sformatf("rst_vld%0d", i), int'(ovld[i]), 0);
    chk($sformatf("rst_pxl%0d", i), int'(opx[i]), 0);
    chk($sformatf("rst_last%0d", i), int'(olast[i]), 0);
    chk($sformatf("rst_err%0d", i), int'(ferr[i]), 0);
    chk($sformatf("rst_rdy%0d", i), int'(irdy[i]), 1);
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++)
        prdy[i] = (rmode[i] == 0) ? ($urandom_range(0, 3) != 0) : (rmode[i] == 1);
    end
  end

  // Monitor: pops scoreboard on each output handshake, checks holding under stall
  initial begin
    logic [1:0]      hold;
    logic [1:0][7:0] hpx;
    logic [1:0]      hl;
    exp_t e;
    hold = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) hold = '0;
      else for (int i = 0; i < 2; i++) begin
        if (hold[i]) begin
          chk($sformatf("hold_vld%0d", i), int'(ovld[i]), 1);
          chk($sformatf("hold_pxl%0d", i), int'(opx[i]), int'(hpx[i]));
          chk($sformatf("hold_last%0d", i), int'(olast[i]), int'(hl[i]));
        end
        if (ovld[i] && prdy[i]) begin
          if ((i == 0 ? q0.size() : q1.size()) == 0) chk($sformatf("unexpected_out%0d", i), int'(opx[i]), -1);
          else begin
            e = (i == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("out_pxl%0d", i), int'(opx[i]), e.d);
            chk($sformatf("out_last%0d", i), int'(olast[i]), e.l);
          end
        end
        hold[i] = ovld[i] & ~prdy[i];
        hpx[i]  = opx[i];
        hl[i]   = olast[i];
        if (ferr[i]) ferr_cnt[i]++;
      end
    end
  end

  initial begin
    logic [7:0] avg_fr[8];
    logic [7:0] mm_fr[8];
    avg_fr = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd81};
    mm_fr  = '{8'd255, 8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6};
    rmode = '{1, 1}; ferr_cnt = '{0, 0}; gaps = 1'b0;
    vin = '0; sof = '0; mode = '0; pix = '0; prdy = '1;
    rst_n = 1'b0;
    #1;
    chk_reset(0); chk_reset(1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // average on 4x2, S=2
    for (int k = 0; k < 8; k++) fr[k] = avg_fr[k];
    push_exp(0, 35, 0); push_exp(0, 55, 1);
    send_frame(0, 8, 0, 1'b1);
    // max then min, with mode_i toggling after the first pixel
    for (int k = 0; k < 8; k++) fr[k] = mm_fr[k];
    push_exp(0, 255, 0); push_exp(0, 6, 1);
    send_frame(0, 8, 1, 1'b1);
    push_exp(0, 0, 0); push_exp(0, 1, 1);
    send_frame(0, 8, 2, 1'b1);
    // decimate and average on 4x4, S=4
    for (int k = 0; k < 16; k++) fr[k] = 8'(k);
    push_exp(1, 0, 1);
    send_frame(1, 16, 3, 1'b1);
    push_exp(1, 7, 1);
    send_frame(1, 16, 0, 1'b1);
    drain();

    // backpressure: first result stalls, next completing pixel must wait
    for (int k = 0; k < 8; k++) fr[k] = avg_fr[k];
    rmode[0] = 2;
    @(posedge clk); #2;
    push_exp(0, 35, 0); push_exp(0, 55, 1);
    for (int k = 0; k < 7; k++) send_px(0, fr[k], k == 0, 2'd0);
    fork
      send_px(0, fr[7], 1'b0, 2'd0);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("bp_in_rdy", int'(irdy[0]), 0);
          chk("bp_out_vld", int'(ovld[0]), 1);
          chk("bp_out_pxl", int'(opx[0]), 35);
        end
        rmode[0] = 1;
      end
    join
    drain();

    // sof at (row 1, col 2): partial block 0 still emitted, then a fresh frame
    for (int k = 0; k < 8; k++) fr[k] = 8'($urandom_range(0, 255));
    push_exp(0, (int'(fr[0]) + int'(fr[1]) + int'(fr[4]) + int'(fr[5])) / 4, 0);
    for (int k = 0; k < 6; k++) send_px(0, fr[k], k == 0, 2'd0);
    for (int k = 0; k < 8; k++) fr[k] = 8'($urandom_range(0, 255));
    model_push(0, 4, 2, 1, 0);
    send_px(0, fr[0], 1'b1, 2'd0);
    chk("sof_err_pulse", int'(ferr[0]), 1);
    for (int k = 1; k < 8; k++) send_px(0, fr[k], 1'b0, 2'($urandom_range(0, 3)));
    drain();

    // reset after 3 pixels; next frame starts at (0,0) without sof
    for (int k = 0; k < 3; k++) send_px(0, 8'(k + 100), k == 0, 2'd1);
    rst_n = 1'b0;
    #1;
    chk_reset(0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 8; k++) fr[k] = avg_fr[k];
    push_exp(0, 35, 0); push_exp(0, 55, 1);
    send_frame(0, 8, 0, 1'b0);
    drain();

    // random frames, modes, gaps and output stalls
    rmode = '{0, 0}; gaps = 1'b1;
    for (int f = 0; f < 15; f++) begin
      int m;
      m = $urandom_range(0, 3);
      for (int k = 0; k < 8; k++) fr[k] = 8'($urandom_range(0, 255));
      model_push(0, 4, 2, 1, m);
      send_frame(0, 8, m, 1'b1);
      m = $urandom_range(0, 3);
      for (int k = 0; k < 16; k++) fr[k] = 8'($urandom_range(0, 255));
      model_push(1, 4, 4, 2, m);
      send_frame(1, 16, m, 1'b1);
    end
    drain();
    repeat (4) @(negedge clk);
    chk("ferr_count0", ferr_cnt[0], 1);
    chk("ferr_count1", ferr_cnt[1], 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pixel_downscaler_nxn.md
# pixel_downscaler_nxn

Parametrised streaming grayscale downscaler. It sits between the DVP state machine and the pixel AXI4 master TX. It reduces each S×S pixel block (S = 2^SCALE_LOG2) to one output pixel, using a pooling mode selected at run time and latched per frame. A single line of accumulators replaces per-position pixel FIFOs, and the block adds frame-start sync, an end-of-frame marker and a frame-error flag.

## Interface
- GS_PXL_W, 8, pixel width
- COL_NUM, 640, input columns per row; must be a multiple of S
- ROW_NUM, 480, input rows per frame; must be a multiple of S
- SCALE_LOG2, 1, log2 of block size S; legal values 1..3
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- mode_i  in  2  pooling mode: 0 average, 1 max, 2 min, 3 decimate (top-left pixel)
- dsm_pxl_i  in  GS_PXL_W  input pixel
- dsm_pxl_vld_i  in  1  input valid
- dsm_sof_i  in  1  start of frame; qualified by dsm_pxl_vld_i and marks pixel (row 0, col 0)
- dsm_pxl_rdy_o  out  1  input ready
- pat_pxl_o  out  GS_PXL_W  output pixel
- pat_pxl_vld_o  out  1  output valid
- pat_last_o  out  1  marks the last output pixel of a frame; valid with pat_pxl_vld_o
- pat_rdy_i  in  1  output ready
- frm_err_o  out  1  one-cycle pulse when dsm_sof_i is accepted while not at (row 0, col 0)

## Operation
- Input handshake: `in_hsk = dsm_pxl_vld_i & dsm_pxl_rdy_o`. Output handshake: `out_hsk = pat_pxl_vld_o & pat_rdy_i`.
- Counters:
  - col_q counts 0..COL_NUM-1. row_q counts 0..ROW_NUM-1.
  - Both advance on in_hsk. col_q wraps to 0 at COL_NUM-1, and row_q increments on that wrap. row_q wraps to 0 after the last pixel of the frame.
- Derived positions: `sub_c = col_q[SCALE_LOG2-1:0]`, `sub_r = row_q[SCALE_LOG2-1:0]`, `blk = col_q >> SCALE_LOG2`.
- Mode latch: mode_q loads mode_i on any in_hsk at (row 0, col 0), including an sof restart. mode_q is constant for the rest of the frame.
- SOF handling: an in_hsk with dsm_sof_i forces that pixel to be treated as (0,0). If the counters were not at (0,0), frm_err_o pulses and the partial frame's accumulators are discarded, because first-pixel writes overwrite them.
- Horizontal register h_acc, ACC_W = GS_PXL_W + 2*SCALE_LOG2 bits:
  - at sub_c == 0, load the pixel (zero-extended);
  - otherwise combine per mode: sum for average, max, min, or hold for decimate.
- Line accumulator lacc[blk], COL_NUM/S entries of ACC_W bits, combinational read:
  - at sub_c == S-1, write `comb(h_acc_next, lacc[blk])`;
  - when sub_r == 0, write h_acc_next directly with no combine.
- Block completion: a pixel with sub_c == S-1 and sub_r == S-1 is a completing pixel. Its result is computed and loaded into the output register instead of being written to lacc.
  - Average: result = sum >> (2*SCALE_LOG2), truncating.
  - Max, min, decimate: result = low GS_PXL_W bits.
- Output register: a single slot (data, last, valid). Loaded with last = 1 when the completing pixel is at row ROW_NUM-1, col COL_NUM-1.
- Backpressure: `dsm_pxl_rdy_o = ~(completing_pixel_position & pat_pxl_vld_o & ~pat_rdy_i)`.
  - Non-completing pixels are always accepted.
  - No pixel or result is dropped.
  - A load and an out_hsk in the same cycle both take effect, and the new data replaces the old.

## Timing
- Reset values: col_q = 0, row_q = 0, mode_q = 0, h_acc = 0, pat_pxl_vld_o = 0, pat_pxl_o = 0, pat_last_o = 0, frm_err_o = 0, dsm_pxl_rdy_o = 1. lacc is not reset.
- Latency: pat_pxl_vld_o rises on the cycle after the completing in_hsk.
- Output holding: pat_pxl_vld_o stays high and pat_pxl_o and pat_last_o stay stable until out_hsk.
- frm_err_o: asserted for exactly the cycle after the offending in_hsk.
- Throughput: 1 input pixel per cycle while pat_rdy_i = 1. Output rate is one pixel per S² inputs.
- Mid-frame reset: all state returns to reset values, a pending output is lost, and the next accepted pixel is treated as (0,0).
- Mode change: a mode_i change mid-frame has no effect until the next frame.

## Test plan
- Average, SCALE_LOG2=1, COL=4, ROW=2. Row 0 = 10,20,30,40; row 1 = 50,60,70,81 -> outputs 35 then 55. pat_last_o = 1 only on 55.
- Max then min on frame {255,0,1,2 / 3,4,5,6}. mode_i=1 -> 255, 6. Next frame with mode_i=2 -> 0, 1. Toggling mode_i mid-frame does not change results.
- Decimate, SCALE_LOG2=2, COL=ROW=4, pixels = index 0..15 -> single output 0 with pat_last_o = 1. Average of the same frame -> 120 >> 4 = 7.
- Backpressure: pat_rdy_i=0 after first output.
  - Non-completing pixels are still accepted.
  - dsm_pxl_rdy_o drops on the next completing pixel and the first output is held stable.
  - Releasing pat_rdy_i drains both outputs in order, with none lost.
- SOF mid-frame: assert dsm_sof_i at (row 1, col 2) -> frm_err_o pulses once; the following S×S block output equals the fresh-frame value.
- Reset mid-frame: assert rst_n low after 3 pixels -> all outputs return to reset values, and the next full frame produces the correct outputs.
